seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle, handshaked ALU: next generation of the team's combinational ALU, with registered operands and results, valid/ready flow control, and parametrised width. Single-cycle ops (add/sub/logic/shift) complete in one cycle. Multiply (shift-add) and divide/remainder (restoring) iterate one bit per cycle. Sits between the operand-issue stage and the writeback buffer in the datapath.

## Interface
- `WIDTH`, 32: operand/result width; legal range 4..64, power of two.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: operands and opcode valid.
- `in_ready`  out  1: block can accept a request.
- `A`, `B`  in  WIDTH: operands.
- `opcode`  in  4: operation select.
- `out_valid`  out  1: result and flags valid.
- `out_ready`  in  1: consumer accepts result.
- `result`  out  WIDTH: registered result.
- `zero`, `carry`, `overflow`, `sign`  out  1 each: registered flags.
- `div_zero`  out  1: divide/remainder with B==0.
- `illegal`  out  1: unsupported opcode.

## Operation
- Opcodes:
  - 0000 ADD; 0001 SUB (A-B); 0010 AND; 0011 OR; 0100 XOR; 0101 NOT A.
  - 0110 SHL; 0111 SHR logical; 1000 SRA. Shift amount is B[$clog2(WIDTH)-1:0].
  - 1001 MUL: low WIDTH bits, unsigned. 1010 DIV: unsigned quotient. 1011 REM: unsigned remainder.
  - Others: result 0, illegal=1, zero=1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, latch A, B, opcode.
  - IDLE → DONE for single-cycle ops, illegal opcodes and divide-by-zero.
  - IDLE → BUSY for MUL/DIV/REM, with counter=WIDTH.
  - BUSY: one iteration per cycle. Counter decrements; →DONE when it reaches 1 and that iteration completes.
  - DONE: out_valid=1. Outputs held stable until out_ready. Then →IDLE.
- Flags, computed on the final result:
  - zero = (result==0); sign = result[WIDTH-1].
  - ADD: carry = carry-out; overflow = signed overflow.
  - SUB: carry = borrow (A<B unsigned); overflow = signed overflow.
  - SHL/SHR/SRA: carry = last bit shifted out, 0 for shift amount 0; overflow=0.
  - MUL: carry = overflow = (upper WIDTH bits of full product ≠ 0).
  - Logic, DIV, REM: carry=0, overflow=0.
- Divide by zero: quotient all ones, remainder = A, div_zero=1, no BUSY phase.
- No new request is accepted while BUSY or DONE (in_ready=0).

## Timing
- Reset state: IDLE, out_valid=0, result=0, all flags 0, counter 0. in_ready=0 while rst is high, 1 the cycle after.
- Reset mid-BUSY or mid-DONE abandons the operation; no out_valid pulse is emitted.
- Latency, accept edge to out_valid:
  - Single-cycle ops, illegal opcodes, divide-by-zero: 1 cycle.
  - MUL/DIV/REM: WIDTH+1 cycles.
- Throughput with out_ready held high:
  - Single-cycle ops: one op per 2 cycles (DONE→IDLE).
  - MUL/DIV/REM: one per WIDTH+2 cycles.
- in_ready is combinational from state only; it never depends on in_valid.
- out_valid and all outputs are registered.

## Configuration
- `SEQ_ALU_DIV_EN`
  - Defined: the restoring divider is compiled in; DIV/REM behave as above.
  - Undefined: divider logic is absent. DIV/REM are treated as illegal: result 0, illegal=1, 1-cycle latency, div_zero never set.

## Structure
- Package `seq_alu_pkg`:
  - opcode enum (`OP_ADD`..`OP_REM`).
  - FSM state enum.
  - `flags_t` struct {zero, carry, overflow, sign, div_zero, illegal}.
- Sub-module `seq_alu_iter`: shared shift-add/restoring-subtract datapath. Accumulator and partial-remainder registers plus the bit counter; start/done handshake to the top FSM.
- Top holds the FSM, the single-cycle combinational ops and the flag logic.

## Test plan
- ADD, WIDTH=32, A=0x7FFFFFFF, B=1 → result 0x80000000, overflow=1, sign=1, carry=0, out_valid 1 cycle after accept.
- SUB, A=5, B=10 → result 0xFFFFFFFB, carry=1, sign=1. SHR A=0x3, B=1 → result 1, carry=1.
- MUL, A=0x10000, B=0x10000 → result 0, carry=overflow=1, zero=1, out_valid at cycle 33.
- DIV, A=100, B=7 → 14; REM → 2, both at cycle 33. DIV, B=0 → 0xFFFFFFFF, div_zero=1 at cycle 1. Without `SEQ_ALU_DIV_EN`: illegal=1.
- Backpressure: out_ready held low 5 cycles in DONE → result stable, in_ready=0, second in_valid ignored until the handshake completes.
- rst asserted at cycle 10 of a MUL → next cycle IDLE, out_valid=0, result=0. A new ADD afterwards completes normally.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types for seq_alu: opcode encoding, FSM states and the registered flag bundle.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_SRA = 4'd8,
    OP_MUL = 4'd9,
    OP_DIV = 4'd10,
    OP_REM = 4'd11
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic sign;
    logic div_zero;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Bit-serial datapath: shift-add multiply and (with SEQ_ALU_DIV_EN) restoring divide.
// hi_o/lo_o expose the post-iteration values so the caller can register them on the done cycle.
module seq_alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
`ifdef SEQ_ALU_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   v;

`ifdef SEQ_ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   x, y;
  logic             cin;
  logic             nb;
  logic [WIDTH+1:0] s;

  // One adder serves both: hi+B for multiply, {hi,lo msb}-B (via ~B+1) for divide.
  always_comb begin
    x    = {1'b0, hi_q};
    y    = {1'b0, b_q};
    cin  = 1'b0;
    hi_d = hi_q;
    lo_d = lo_q;
    v    = '0;
    if (div_q) begin
      x   = {hi_q, lo_q[WIDTH-1]};
      y   = ~{1'b0, b_q};
      cin = 1'b1;
    end
    s  = {1'b0, x} + {1'b0, y} + {{(WIDTH+1){1'b0}}, cin};
    nb = s[WIDTH+1];
    if (div_q) begin
      hi_d = nb ? s[WIDTH-1:0] : x[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], nb};
    end else begin
      v    = lo_q[0] ? s[WIDTH:0] : x;
      hi_d = v[WIDTH:1];
      lo_d = {v[0], lo_q[WIDTH-1:1]};
    end
  end
`else
  logic [WIDTH:0] s;

  always_comb begin
    s    = {1'b0, hi_q} + {1'b0, b_q};
    v    = lo_q[0] ? s : {1'b0, hi_q};
    hi_d = v[WIDTH:1];
    lo_d = {v[0], lo_q[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start_i) begin
      hi_q  <= '0;
      lo_q  <= a_i;
      b_q   <= b_i;
      cnt_q <= CW'(WIDTH);
`ifdef SEQ_ALU_DIV_EN
      div_q <= div_i;
`endif
    end else if (cnt_q != '0) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done_o = (cnt_q == CW'(1));
  assign hi_o   = hi_d;
  assign lo_o   = lo_d;

endmodule

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-cycle ops in one cycle, MUL/DIV/REM iterate bit-serially.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise DIV/REM report illegal.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             sign,
  output logic             div_zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  state_t           state_q;
  opcode_t          op_q;
  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;
  logic             out_valid_q;

  opcode_t          op;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_fl;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   wide;
  logic             iter_req;
  logic             start_iter;
  logic             iter_done;
  logic [WIDTH-1:0] iter_hi, iter_lo;
  logic [WIDTH-1:0] iter_res;
  flags_t           iter_fl;
`ifdef SEQ_ALU_DIV_EN
  logic             div_sel;
  logic             b_zero;
  assign b_zero = (B == '0);
`endif

  assign op    = opcode_t'(opcode);
  assign shamt = B[SW-1:0];

  always_comb begin
    alu_res  = '0;
    alu_fl   = '0;
    sum      = '0;
    wide     = '0;
    iter_req = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    div_sel  = 1'b0;
`endif
    case (op)
      OP_ADD: begin
        sum             = {1'b0, A} + {1'b0, B};
        alu_res         = sum[WIDTH-1:0];
        alu_fl.carry    = sum[WIDTH];
        alu_fl.overflow = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sum             = {1'b0, A} - {1'b0, B};
        alu_res         = sum[WIDTH-1:0];
        alu_fl.carry    = sum[WIDTH];
        alu_fl.overflow = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_NOT: alu_res = ~A;
      // The extra guard bit catches the last bit shifted out (zero for a shift of 0).
      OP_SHL: begin
        wide         = {1'b0, A} << shamt;
        alu_res      = wide[WIDTH-1:0];
        alu_fl.carry = wide[WIDTH];
      end
      OP_SHR: begin
        wide         = {A, 1'b0} >> shamt;
        alu_res      = wide[WIDTH:1];
        alu_fl.carry = wide[0];
      end
      OP_SRA: begin
        wide         = $signed({A, 1'b0}) >>> shamt;
        alu_res      = wide[WIDTH:1];
        alu_fl.carry = wide[0];
      end
      OP_MUL: iter_req = 1'b1;
`ifdef SEQ_ALU_DIV_EN
      OP_DIV, OP_REM: begin
        if (b_zero) begin
          alu_res         = (op == OP_DIV) ? '1 : A;
          alu_fl.div_zero = 1'b1;
        end else begin
          iter_req = 1'b1;
          div_sel  = 1'b1;
        end
      end
`endif
      default: alu_fl.illegal = 1'b1;
    endcase
    alu_fl.zero = (alu_res == '0);
    alu_fl.sign = alu_res[WIDTH-1];
  end

  assign start_iter = (state_q == S_IDLE) && in_valid && iter_req;

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start_iter),
`ifdef SEQ_ALU_DIV_EN
    .div_i   (div_sel),
`endif
    .a_i     (A),
    .b_i     (B),
    .done_o  (iter_done),
    .hi_o    (iter_hi),
    .lo_o    (iter_lo)
  );

  always_comb begin
    iter_fl  = '0;
    iter_res = iter_lo;
    if (op_q == OP_REM) iter_res = iter_hi;
    if (op_q == OP_MUL) begin
      iter_fl.carry    = (iter_hi != '0);
      iter_fl.overflow = (iter_hi != '0);
    end
    iter_fl.zero = (iter_res == '0);
    iter_fl.sign = iter_res[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= op;
            if (iter_req) begin
              state_q <= S_BUSY;
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              flags_q     <= alu_fl;
            end
          end
        end
        S_BUSY: begin
          if (iter_done) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= iter_res;
            flags_q     <= iter_fl;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Gated by rst so nothing is offered while the block is held in reset.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign sign      = flags_q.sign;
  assign div_zero  = flags_q.div_zero;
  assign illegal   = flags_q.illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32); DIV/REM expectations follow SEQ_ALU_DIV_EN.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, result;
  logic [3:0]   opcode;
  logic         zero, carry, overflow, sign, div_zero, illegal;

  typedef struct {
    logic [W-1:0] res;
    flags_t       fl;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   lat_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow),
    .sign(sign), .div_zero(div_zero), .illegal(illegal)
  );

  function automatic flags_t mkf(input logic z, c, o, s, d, i);
    return {z, c, o, s, d, i};
  endfunction

  function automatic flags_t act_fl();
    return {zero, carry, overflow, sign, div_zero, illegal};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input flags_t ef, input int lat);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    A        = a;
    B        = b;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.res = er; e.fl = ef; e.lat = lat; e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  // Monitor: latency on first sight of out_valid, stability while stalled, values on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        if (!lat_done) begin
          chk("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
          lat_done = 1;
        end
        if (!out_ready) begin
          chk("hold_result", result, q[0].res);
          chk("hold_flags", act_fl(), q[0].fl);
        end else begin
          chk("result", result, q[0].res);
          chk("flags", act_fl(), q[0].fl);
          void'(q.pop_front());
          lat_done = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", act_fl(), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    issue(4'h0, 32'h7FFFFFFF, 32'h1,        32'h80000000, mkf(0,0,1,1,0,0), 1);
    issue(4'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        mkf(1,1,0,0,0,0), 1);
    issue(4'h1, 32'd5,        32'd10,       32'hFFFFFFFB, mkf(0,1,0,1,0,0), 1);
    issue(4'h1, 32'h80000000, 32'h1,        32'h7FFFFFFF, mkf(0,0,1,0,0,0), 1);
    issue(4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, mkf(0,0,0,1,0,0), 1);
    issue(4'h3, 32'h0F,       32'hF0,       32'hFF,       mkf(0,0,0,0,0,0), 1);
    issue(4'h4, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0,        mkf(1,0,0,0,0,0), 1);
    issue(4'h5, 32'h0,        32'h1234,     32'hFFFFFFFF, mkf(0,0,0,1,0,0), 1);
    issue(4'h6, 32'h80000001, 32'd1,        32'h2,        mkf(0,1,0,0,0,0), 1);
    issue(4'h6, 32'h80000000, 32'd32,       32'h80000000, mkf(0,0,0,1,0,0), 1);
    issue(4'h7, 32'h3,        32'd1,        32'h1,        mkf(0,1,0,0,0,0), 1);
    issue(4'h8, 32'h80000000, 32'd4,        32'hF8000000, mkf(0,0,0,1,0,0), 1);
    issue(4'h8, 32'h8000000F, 32'd4,        32'hF8000000, mkf(0,1,0,1,0,0), 1);
    issue(4'hF, 32'h1,        32'h2,        32'h0,        mkf(1,0,0,0,0,1), 1);
    issue(4'h9, 32'h10000,    32'h10000,    32'h0,        mkf(1,1,1,0,0,0), 33);
    issue(4'h9, 32'd3,        32'd5,        32'd15,       mkf(0,0,0,0,0,0), 33);
    issue(4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        mkf(0,1,1,0,0,0), 33);
`ifdef SEQ_ALU_DIV_EN
    issue(4'hA, 32'd100,      32'd7,        32'd14,       mkf(0,0,0,0,0,0), 33);
    issue(4'hB, 32'd100,      32'd7,        32'd2,        mkf(0,0,0,0,0,0), 33);
    issue(4'hB, 32'd7,        32'd100,      32'd7,        mkf(0,0,0,0,0,0), 33);
    issue(4'hA, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, mkf(0,0,0,1,0,0), 33);
    issue(4'hA, 32'd5,        32'd0,        32'hFFFFFFFF, mkf(0,0,0,1,1,0), 1);
    issue(4'hB, 32'h1234,     32'd0,        32'h1234,     mkf(0,0,0,0,1,0), 1);
`else
    issue(4'hA, 32'd100,      32'd7,        32'h0,        mkf(1,0,0,0,0,1), 1);
    issue(4'hB, 32'd100,      32'd7,        32'h0,        mkf(1,0,0,0,0,1), 1);
    issue(4'hA, 32'd5,        32'd0,        32'h0,        mkf(1,0,0,0,0,1), 1);
`endif

    // Backpressure: hold the consumer off for 5 cycles while a second request waits.
    issue(4'h0, 32'd1, 32'd2, 32'd3, mkf(0,0,0,0,0,0), 1);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      issue(4'h1, 32'd9, 32'd4, 32'd5, mkf(0,0,0,0,0,0), 1);
    join

    // Reset in the middle of a multiply: the result must never appear.
    issue(4'h9, 32'd7, 32'd9, 32'd63, mkf(0,0,0,0,0,0), 33);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    lat_done = 0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", act_fl(), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("midrst_no_stale_valid", bad, 0);
    issue(4'h0, 32'd2, 32'd3, 32'd5, mkf(0,0,0,0,0,0), 1);

    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
